// File: rtl/dm_arb_if.sv
// dm_arb_if -- bundle of every signal between the dual-port memory arbiter,
// its two requesting ports and the shared data memory.
//
//   p0_* / p1_*  request side: req, we, addr, din, bmode, bsel in;
//                ack (one-cycle completion pulse) and dout (read data) out
//   m_*          memory side: addr, din, we, bmode, bsel out of the arbiter;
//                m_dout (combinational, byte-extended read data) into it
//   busy         arbiter is in ACCESS or DONE
//
// Modports: slave = arbiter view, master = environment (ports + memory) view.
interface dm_arb_if #(
  parameter int ADDR_W = 10
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [31:0]       p0_din;
  logic              p0_bmode;
  logic [1:0]        p0_bsel;
  logic              p0_ack;
  logic [31:0]       p0_dout;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [31:0]       p1_din;
  logic              p1_bmode;
  logic [1:0]        p1_bsel;
  logic              p1_ack;
  logic [31:0]       p1_dout;

  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_din;
  logic              m_we;
  logic              m_bmode;
  logic [1:0]        m_bsel;
  logic [31:0]       m_dout;

  logic              busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_din, p0_bmode, p0_bsel,
    output p0_ack, p0_dout,
    input  p1_req, p1_we, p1_addr, p1_din, p1_bmode, p1_bsel,
    output p1_ack, p1_dout,
    output m_addr, m_din, m_we, m_bmode, m_bsel,
    input  m_dout,
    output busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_din, p0_bmode, p0_bsel,
    input  p0_ack, p0_dout,
    output p1_req, p1_we, p1_addr, p1_din, p1_bmode, p1_bsel,
    input  p1_ack, p1_dout,
    input  m_addr, m_din, m_we, m_bmode, m_bsel,
    output m_dout,
    input  busy
  );
endinterface

// File: rtl/dm_arb.sv
// dm_arb -- two-port arbiter in front of a single shared data memory.
// Each access runs IDLE -> ACCESS -> DONE: the owner is chosen in IDLE, its
// request is forwarded to the memory for the single ACCESS cycle, and its ack
// pulses in DONE with registered read data on its dout.
//
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  dm_arb_if.slave (p0_*, p1_* request ports, m_* memory side, busy)
//
// Build option: define DM_ARB_FIXED_PRIO_EN to make port 0 win every tie;
// by default ties are resolved round-robin against the last-served port.
module dm_arb #(
  parameter int ADDR_W = 10
) (
  input  logic      clk,
  input  logic      rst,
  dm_arb_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   owner, owner_nx;
  logic   grant;
`ifndef DM_ARB_FIXED_PRIO_EN
  logic   last;
`endif

  // Owner's request fields
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_din;
  logic              sel_bmode;
  logic [1:0]        sel_bsel;
  logic              in_access;

  always_comb begin
    sel_we    = owner ? bus.p1_we    : bus.p0_we;
    sel_addr  = owner ? bus.p1_addr  : bus.p0_addr;
    sel_din   = owner ? bus.p1_din   : bus.p0_din;
    sel_bmode = owner ? bus.p1_bmode : bus.p0_bmode;
    sel_bsel  = owner ? bus.p1_bsel  : bus.p0_bsel;
  end

  // Port chosen if a request is sampled this cycle. With a single requester
  // ~p0_req picks it; on a tie it falls to the priority rule.
  always_comb begin
`ifdef DM_ARB_FIXED_PRIO_EN
    grant = ~bus.p0_req;
`else
    if (bus.p0_req && bus.p1_req)
      grant = ~last;
    else
      grant = ~bus.p0_req;
`endif
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    case (state)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          owner_nx = grant;
          state_nx = ACCESS;
        end
      end
      ACCESS:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
    end
  end

  // Read data capture and last-served update on the edge ending ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.p0_dout <= '0;
      bus.p1_dout <= '0;
`ifndef DM_ARB_FIXED_PRIO_EN
      last        <= 1'b1;
`endif
    end else if (state == ACCESS) begin
      if (!sel_we) begin
        if (owner) bus.p1_dout <= bus.m_dout;
        else       bus.p0_dout <= bus.m_dout;
      end
`ifndef DM_ARB_FIXED_PRIO_EN
      last <= owner;
`endif
    end
  end

  // Memory side is a pure decode of the state register, so an asynchronous
  // reset mid-ACCESS drops m_we without waiting for a clock.
  assign in_access = (state == ACCESS);

  always_comb begin
    bus.m_we    = in_access & sel_we;
    bus.m_addr  = in_access ? sel_addr  : '0;
    bus.m_din   = in_access ? sel_din   : '0;
    bus.m_bmode = in_access ? sel_bmode : 1'b0;
    bus.m_bsel  = in_access ? sel_bsel  : '0;
    bus.p0_ack  = (state == DONE) && !owner;
    bus.p1_ack  = (state == DONE) &&  owner;
    bus.busy    = (state != IDLE);
  end

endmodule
